// File: rtl/ff_bank_seq_if.sv
// Command handshake bundle between fabric control logic and the FF-bank sequencer.
interface ff_bank_seq_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cmd_mask;

  modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_mask,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  cmd_mask,
                  output cmd_ready);
endinterface

// File: rtl/ff_bank_seq.sv
// Load/clear/preset sequencer driving QEN/D/QST/QRT of a bank of ff primitives.
// Optional CQZ readback check enabled by defining FF_BANK_SEQ_VERIFY_EN.
module ff_bank_seq #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic             QCK,
  input  logic             QRTN,
  ff_bank_seq_if.slave     cmd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] QEN,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] QST,
  output logic [WIDTH-1:0] QRT,
  input  logic [WIDTH-1:0] CQZ,
  output logic             err
);

  localparam int CNT_MAX = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD = (RECOV_CYC > 0) ? CNT_W'(RECOV_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PRESET = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN,
    S_PULSE,
    S_RECOV,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, done_reg, err_reg, err_next;
  logic [WIDTH-1:0] qen_reg, d_reg, qst_reg, qrt_reg;
  logic [WIDTH-1:0] qen_next, d_next, qst_next, qrt_next;
  logic             accept;
  logic             en_phase, clr_phase, set_phase;

  assign cmd.cmd_ready = (state_reg == S_IDLE) & QRTN;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    mask_next  = mask_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          op_next   = cmd.cmd_op;
          data_next = cmd.cmd_data;
          mask_next = cmd.cmd_mask;
          case (cmd.cmd_op)
            OP_NOP:  state_next = S_DONE;
            OP_LOAD: state_next = S_EN;
            default: begin
              state_next = S_PULSE;
              cnt_next   = PULSE_LD;
            end
          endcase
        end
      end
      S_EN: state_next = S_DONE;
      S_PULSE: begin
        if (cnt_reg == '0) begin
          if (RECOV_CYC == 0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RECOV;
            cnt_next   = RECOV_LD;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_RECOV: begin
        if (cnt_reg == '0) state_next = S_DONE;
        else               cnt_next   = cnt_reg - CNT_ONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Drive values are decoded from the upcoming state so the pins change on the same edge as the state.
  assign en_phase  = (state_next == S_EN);
  assign clr_phase = (state_next == S_PULSE) && (op_next == OP_CLEAR);
  assign set_phase = (state_next == S_PULSE) && (op_next == OP_PRESET);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign qen_next[gi] = en_phase  & mask_next[gi];
    assign d_next[gi]   = en_phase  & mask_next[gi] & data_next[gi];
    assign qrt_next[gi] = clr_phase & mask_next[gi];
    assign qst_next[gi] = set_phase & mask_next[gi];
  end

`ifdef FF_BANK_SEQ_VERIFY_EN
  logic [WIDTH-1:0] expect_val;
  logic             mismatch;

  always_comb begin
    case (op_reg)
      OP_LOAD:   expect_val = data_reg;
      OP_PRESET: expect_val = '1;
      default:   expect_val = '0;
    endcase
  end

  assign mismatch = (state_reg == S_DONE) && (op_reg != OP_NOP) &&
                    (((CQZ ^ expect_val) & mask_reg) != '0);
  assign err_next = accept ? 1'b0 : (err_reg | mismatch);
`else
  logic unused_cqz;
  assign unused_cqz = ^CQZ;
  assign err_next   = 1'b0;
`endif

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      qen_reg   <= '0;
      d_reg     <= '0;
      qst_reg   <= '0;
      qrt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      mask_reg  <= mask_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_next == S_DONE);
      err_reg   <= err_next;
      qen_reg   <= qen_next;
      d_reg     <= d_next;
      qst_reg   <= qst_next;
      qrt_reg   <= qrt_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;
  assign QEN  = qen_reg;
  assign D    = d_reg;
  assign QST  = qst_reg;
  assign QRT  = qrt_reg;

endmodule

// File: tb/tb_ff_bank_seq.sv
// Bench for ff_bank_seq: table vectors, random commands vs. a cycle-timeline model, reset corners.
module tb_ff_bank_seq;
  localparam int W  = 8;
  localparam int P  = 2;
  localparam int RA = 1;
  localparam int RB = 0;
`ifdef FF_BANK_SEQ_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic qck  = 1'b0;
  logic qrtn = 1'b0;
  always #5 qck = ~qck;

  ff_bank_seq_if #(.WIDTH(W)) bus_a ();
  ff_bank_seq_if #(.WIDTH(W)) bus_b ();

  logic         busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [W-1:0] qen_a, d_a, qst_a, qrt_a, cqz_a;
  logic [W-1:0] qen_b, d_b, qst_b, qrt_b, cqz_b;

  ff_bank_seq #(.WIDTH(W), .PULSE_CYC(P), .RECOV_CYC(RA)) u_dut_a (
    .QCK(qck), .QRTN(qrtn), .cmd(bus_a), .busy(busy_a), .done(done_a),
    .QEN(qen_a), .D(d_a), .QST(qst_a), .QRT(qrt_a), .CQZ(cqz_a), .err(err_a)
  );
  ff_bank_seq #(.WIDTH(W), .PULSE_CYC(P), .RECOV_CYC(RB)) u_dut_b (
    .QCK(qck), .QRTN(qrtn), .cmd(bus_b), .busy(busy_b), .done(done_b),
    .QEN(qen_b), .D(d_b), .QST(qst_b), .QRT(qrt_b), .CQZ(cqz_b), .err(err_b)
  );

  typedef struct packed {
    logic         ready, busy, done, err;
    logic [W-1:0] qen, d, qst, qrt;
  } obs_t;

  typedef struct {
    int           sel;
    logic [1:0]   op;
    logic [W-1:0] data, mask, cqz;
    int           len;
    logic [W-1:0] e_qen, e_d, e_qst, e_qrt;
    logic         e_err;
    string        name;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) o = '{bus_a.cmd_ready, busy_a, done_a, err_a, qen_a, d_a, qst_a, qrt_a};
    else          o = '{bus_b.cmd_ready, busy_b, done_b, err_b, qen_b, d_b, qst_b, qrt_b};
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [1:0] op,
                       input logic [W-1:0] data, input logic [W-1:0] mask);
    if (sel == 0) begin
      bus_a.cmd_valid = v; bus_a.cmd_op = op; bus_a.cmd_data = data; bus_a.cmd_mask = mask;
    end else begin
      bus_b.cmd_valid = v; bus_b.cmd_op = op; bus_b.cmd_data = data; bus_b.cmd_mask = mask;
    end
  endtask

  // Completion cycle (counted from the accept edge) for a command on a DUT with recovery r.
  function automatic int exp_len(input logic [1:0] op, input int r);
    case (op)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 1 + P + r;
    endcase
  endfunction

  // Expected timeline: cycle 1..len busy, drive in the leading phase, done at len, idle after.
  task automatic run_vec(input vec_t v, input bit junk);
    obs_t o, e;
    @(negedge qck);
    drive(v.sel, 1'b1, v.op, v.data, v.mask);
    if (v.sel == 0) cqz_a = v.cqz; else cqz_b = v.cqz;
    o = sample(v.sel);
    e = o;
    e.ready = 1'b1;
    check({v.name, "_ready"}, 0, o, e);
    for (int n = 1; n <= v.len + 1; n++) begin
      @(negedge qck);
      o = sample(v.sel);
      e = '0;
      if (n <= v.len) begin
        e.busy = 1'b1;
        e.done = (n == v.len);
        if (v.op == 2'b01 && n == 1) begin
          e.qen = v.e_qen;
          e.d   = v.e_d;
        end
        if (v.op[1] && n <= P) begin
          e.qst = v.e_qst;
          e.qrt = v.e_qrt;
        end
      end else begin
        e.ready = 1'b1;
        e.err   = v.e_err;
      end
      check(v.name, n, o, e);
      if (n <= v.len && junk)
        drive(v.sel, 1'b1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      else
        drive(v.sel, 1'b0, 2'b00, '0, '0);
    end
    $display("txn %s dut=%0d op=%0d data=%h mask=%h cqz=%h len=%0d junk=%0d",
             v.name, v.sel, v.op, v.data, v.mask, v.cqz, v.len, junk);
  endtask

  vec_t tbl[8];

  initial begin
    obs_t o;
    vec_t v;
    logic [W-1:0] ev;

    drive(0, 1'b0, 2'b00, '0, '0);
    drive(1, 1'b0, 2'b00, '0, '0);
    cqz_a = '0;
    cqz_b = '0;

    tbl[0] = '{0, 2'b01, 8'hA5, 8'hF0, 8'hA0, 2,     8'hF0, 8'hA0, 8'h00, 8'h00, 1'b0, "load_a5_f0"};
    tbl[1] = '{0, 2'b10, 8'h00, 8'hFF, 8'h00, 1+P+RA, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "clear_ff"};
    tbl[2] = '{1, 2'b11, 8'h00, 8'h0F, 8'h0F, 1+P+RB, 8'h00, 8'h00, 8'h0F, 8'h00, 1'b0, "preset_norecov"};
    tbl[3] = '{0, 2'b01, 8'h3C, 8'hFF, 8'h3D, 2,     8'hFF, 8'h3C, 8'h00, 8'h00, VER,  "load_badrb"};
    tbl[4] = '{0, 2'b00, 8'h55, 8'hFF, 8'h00, 1,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "nop_clr_err"};
    tbl[5] = '{0, 2'b11, 8'hFF, 8'h00, 8'h00, 1+P+RA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "preset_mask0"};
    tbl[6] = '{1, 2'b10, 8'h00, 8'h3C, 8'hC3, 1+P+RB, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b0, "clear_b_3c"};
    tbl[7] = '{0, 2'b01, 8'hFF, 8'h00, 8'h00, 2,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "load_mask0"};

    // Reset held: everything low, cmd_ready low on both units.
    repeat (2) @(negedge qck);
    check("rst_a", 0, sample(0), '0);
    check("rst_b", 0, sample(1), '0);
    qrtn = 1'b1;
    @(negedge qck);
    o = '0; o.ready = 1'b1;
    check("idle_a", 0, sample(0), o);
    check("idle_b", 0, sample(1), o);

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    for (int k = 0; k < 40; k++) begin
      v.sel  = int'($urandom_range(0, 1));
      v.op   = 2'($urandom_range(0, 3));
      v.data = W'($urandom);
      v.mask = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      case (v.op)
        2'b01:   ev = v.data;
        2'b11:   ev = '1;
        default: ev = '0;
      endcase
      v.cqz = (ev & v.mask) | (W'($urandom) & ~v.mask);
      if ($urandom_range(0, 3) == 0) v.cqz ^= W'($urandom);
      v.len   = exp_len(v.op, (v.sel == 0) ? RA : RB);
      v.e_qen = (v.op == 2'b01) ? v.mask : '0;
      v.e_d   = (v.op == 2'b01) ? (v.data & v.mask) : '0;
      v.e_qst = (v.op == 2'b11) ? v.mask : '0;
      v.e_qrt = (v.op == 2'b10) ? v.mask : '0;
      v.e_err = VER && (v.op != 2'b00) && (((v.cqz ^ ev) & v.mask) != '0);
      v.name  = $sformatf("rnd%0d", k);
      run_vec(v, 1'($urandom_range(0, 1)));
    end

    // Reset during a PRESET pulse: pins drop at once, no done afterwards.
    @(negedge qck);
    drive(0, 1'b1, 2'b11, 8'h00, 8'hF0);
    @(negedge qck);
    drive(0, 1'b0, 2'b00, '0, '0);
    o = '0; o.busy = 1'b1; o.qst = 8'hF0;
    check("midpulse_pre", 1, sample(0), o);
    #2 qrtn = 1'b0;
    #1 check("midpulse_async", 1, sample(0), '0);
    @(negedge qck);
    check("midpulse_held", 2, sample(0), '0);
    qrtn = 1'b1;
    @(negedge qck);
    o = '0; o.ready = 1'b1;
    check("midpulse_release", 3, sample(0), o);
    @(negedge qck);
    check("midpulse_nodone", 4, sample(0), o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ff_bank_seq.md
Name: ff_bank_seq

Overview:
- Command sequencer for a bank of WIDTH `ff` primitives.
- Translates load/clear/preset commands into correctly timed per-bit QEN/D/QST/QRT drive.
- Enforces a minimum async set/reset pulse width and a recovery gap before the next clocked operation.
- Sits between fabric control logic and the FF bank; one command at a time via a valid/ready handshake.

Parameters:
- WIDTH, 8, number of FFs driven (bits per bus).
- PULSE_CYC, 2, cycles QST/QRT are held asserted (legal range 1..255).
- RECOV_CYC, 1, idle cycles after the pulse before done (legal range 0..255; 0 skips RECOV).

Ports:
- QCK  in  1  clock, shared with the FF bank.
- QRTN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  command: 00 NOP, 01 LOAD, 10 CLEAR, 11 PRESET.
- cmd_data  in  WIDTH  LOAD value.
- cmd_mask  in  WIDTH  bits affected by the command (1 = affected).
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- QEN  out  WIDTH  per-FF enable.
- D  out  WIDTH  per-FF data.
- QST  out  WIDTH  per-FF async set.
- QRT  out  WIDTH  per-FF async reset.
- CQZ  in  WIDTH  FF bank outputs (used only with the optional feature).
- err  out  1  readback mismatch (optional feature; tied 0 otherwise).

Behaviour:
- All outputs are registered except cmd_ready = (state==IDLE) & QRTN.
- Reset (QRTN low, async): state=IDLE; QEN, D, QST, QRT = 0; busy=0; done=0; err=0; latched op/data/mask cleared.
- Accept a command on the QCK edge where cmd_valid & cmd_ready; latch op, data, mask.
- States: IDLE, EN, PULSE, RECOV, DONE.
  - IDLE, accepted LOAD -> EN.
  - IDLE, accepted CLEAR/PRESET -> PULSE; load counter with PULSE_CYC-1.
  - IDLE, accepted NOP -> DONE.
  - EN (1 cycle): QEN=mask, D=data&mask -> DONE.
  - PULSE: CLEAR drives QRT=mask; PRESET drives QST=mask; counter decrements each cycle. At 0 -> RECOV (counter=RECOV_CYC-1), or -> DONE if RECOV_CYC==0.
  - RECOV: QST=QRT=QEN=0; at counter 0 -> DONE.
  - DONE (1 cycle): done=1, busy=1 -> IDLE.
- Latency from accept edge k:
  - LOAD: EN in cycle k+1, done in cycle k+2.
  - CLEAR/PRESET: done in cycle k+1+PULSE_CYC+RECOV_CYC.
  - NOP: done in cycle k+1.
- QST and QRT are never asserted in the same cycle. QEN is never asserted in the same cycle as QST or QRT.
- Outside EN, QEN=0 and D=0. Outside PULSE, QST=QRT=0.
- cmd_mask=0: full sequence still runs and done still pulses; all per-bit outputs stay 0.
- cmd_ready is 0 from the accept edge through DONE. Back-to-back: next accept possible on the edge ending DONE+1 (earliest in IDLE).
- cmd_valid while busy: ignored and not queued; the requester must hold it.
- Reset mid-operation: outputs drop to 0 immediately (async); no done; FF bank contents are undefined to the bench.
- Counter width is $clog2(max(PULSE_CYC,RECOV_CYC)+1), minimum 1.

Optional Feature:
- Macro FF_BANK_SEQ_VERIFY_EN.
- Defined:
  - In DONE, compare CQZ&mask against expected&mask. Expected is data for LOAD, 0 for CLEAR, all-ones for PRESET; NOP never errors.
  - Mismatch sets err on the edge ending DONE.
  - err is sticky until the next accepted command clears it.
- Not defined: CQZ is unused and err is tied 0.

Test Plan:
- Reset release, idle: QRTN low then high, cmd_valid=0 -> all outputs 0, cmd_ready=1, busy=0.
- LOAD, WIDTH=8: cmd_op=01, cmd_data=8'hA5, cmd_mask=8'hF0 -> exactly one cycle with QEN=8'hF0, D=8'hA0; done next cycle; bank low nibble unchanged.
- CLEAR, PULSE_CYC=2, RECOV_CYC=1: mask=8'hFF -> QRT=8'hFF for 2 cycles, 1 idle cycle, done 4 cycles after accept; CQZ=8'h00.
- PRESET, RECOV_CYC=0, mask=8'h0F -> QST=8'h0F for PULSE_CYC cycles, done the following cycle; QRT stays 0 throughout.
- Reset mid-PULSE: QRTN low during PRESET pulse -> QST=0 immediately, no done, cmd_ready=0 while low, 1 after release.
- VERIFY_EN: LOAD data=8'h3C mask=8'hFF with CQZ forced to 8'h3D -> err=1 after DONE. Next NOP accept -> err=0.
